init_skid_buffer: RTL and testbench
===================================

Name: init_skid_buffer

Overview:
Two-entry valid/ready skid buffer that sits directly upstream of the Gowin DFF primitive bank and feeds its D/CE inputs.
- Every storage bit is a preset-capable flop whose power-up/preset value is a parameterised INIT pattern, so it maps onto DFFP/DFFPE/DFFC/DFFCE cells.
- Provides a registered in_ready: full throughput, no combinational ready path from out_ready to in_ready.

Parameters:
WIDTH, 8, data width in bits (>=1).
INIT, {WIDTH{1'b0}}, value loaded into main and skid data registers at power-up and on PRESET; bit i selects preset (1) or clear (0) flop for that bit.

Ports:
CLK  input  1  clock, rising edge.
PRESET  input  1  reset, asynchronous, active-high.
in_valid  input  1  upstream data valid.
in_ready  output  1  buffer can accept; registered.
in_data  input  WIDTH  upstream data.
out_valid  output  1  main register holds valid data.
out_ready  input  1  downstream accepts.
out_data  output  WIDTH  main register contents.
occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (PRESET high, async, dominates everything):
  - state=EMPTY, out_valid=0, in_ready=0, occupancy=0.
  - out_data=INIT, skid register=INIT.
  - Initial values equal these reset values.
  - in_ready rises at the first CLK edge after PRESET falls.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer occurs only on a rising CLK edge.
- States (occupancy mirrors the state: 0/1/2):
  - EMPTY: in_fire -> main<=in_data, ONE. Otherwise hold.
  - ONE, out_fire only: -> EMPTY; main holds its last value (not cleared).
  - ONE, in_fire only: skid<=in_data, -> FULL, in_ready<=0.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE.
  - FULL (in_ready=0, in_valid ignored): out_fire -> main<=skid, -> ONE, in_ready<=1. Otherwise hold.
- out_valid = (state!=EMPTY). Registered, no combinational path from inputs.
- in_ready = registered (next_state!=FULL), and 0 while PRESET is asserted.
- Latency: in_fire at edge N -> out_valid=1 with that data after edge N (visible in cycle N+1). Sustained throughput 1 word/cycle with out_ready held high.
- Ordering: strict FIFO. The skid entry is always older than any later input.
- Data is never duplicated or dropped. in_valid with in_ready=0 has no effect.
- Upstream may change in_data while in_valid=1 and in_ready=0; only data present at in_fire is captured.
- PRESET mid-operation: both entries discarded; registers return to INIT immediately, not waiting for CLK.
- X on in_data when in_fire=0 must not propagate into held registers.

Optional Feature:
Macro INIT_SKID_SCLR_EN.
- Defined: adds input port SCLR (1 bit, synchronous, active-high), mapping onto DFFS/DFFR cells.
  - At a CLK edge with SCLR=1: state<=EMPTY, main and skid<=INIT, in_ready<=1, occupancy<=0.
  - Any simultaneous in_fire or out_fire is discarded.
  - PRESET has priority over SCLR.
- Undefined: no SCLR port; only PRESET clears the buffer.

Test Plan:
1. PRESET pulse between edges with WIDTH=8, INIT=8'hA5 -> out_data=8'hA5, out_valid=0, in_ready=0 immediately; in_ready=1 one edge after PRESET falls.
2. Stream 0x01..0x10 with in_valid=1 and out_ready=1 every cycle -> outputs 0x01..0x10 in order, one per cycle, first one cycle after first in_fire; occupancy stays 1.
3. Load 0x11, then hold out_ready=0 and present 0x22 -> occupancy=2, in_ready=0; 0x33 offered is ignored. Raise out_ready -> 0x11 then 0x22 out; in_ready=1 after the first out_fire.
4. Random in_valid/out_ready at 50% each for 10k cycles -> scoreboard shows exact FIFO order, no loss or duplication; in_ready never 1 when occupancy=2.
5. Assert PRESET asynchronously while FULL (0x44, 0x55) -> out_valid=0 and out_data=INIT before the next edge; after release neither 0x44 nor 0x55 ever appears.
6. (INIT_SKID_SCLR_EN) With FULL and in_valid=1, out_ready=1, assert SCLR for one edge -> occupancy=0, out_data=INIT, in_ready=1; no data transferred that edge.

Source files
------------

// File: rtl/init_skid_buffer_if.sv
// rtl/init_skid_buffer_if.sv - valid/ready handshake bundle for init_skid_buffer
//
// Purpose: groups the upstream and downstream handshake signals of the skid buffer.
// Signals:
//   in_valid / in_ready / in_data     upstream handshake and data
//   out_valid / out_ready / out_data  downstream handshake and data
//   occupancy                         entries held by the buffer (0, 1 or 2)
// Modports:
//   slave  - the buffer side
//   master - the side that drives the buffer and consumes its output
interface init_skid_buffer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/init_skid_buffer.sv
// rtl/init_skid_buffer.sv - two-entry valid/ready skid buffer with INIT-valued preset flops
//
// Purpose: two-entry skid buffer with a registered in_ready. Every data flop
// powers up and presets to INIT, so each bit maps onto a preset or clear cell.
// Ports:
//   CLK     clock, rising edge
//   PRESET  asynchronous active-high reset; returns the buffer to EMPTY with data = INIT
//   SCLR    synchronous active-high clear (only with INIT_SKID_SCLR_EN defined)
//   bus     init_skid_buffer_if.slave: in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data, occupancy
// Optional feature: define INIT_SKID_SCLR_EN to add the SCLR port.
module init_skid_buffer #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic              CLK,
    input  logic              PRESET,
`ifdef INIT_SKID_SCLR_EN
    input  logic              SCLR,
`endif
    init_skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             sclr;

`ifdef INIT_SKID_SCLR_EN
    assign sclr = SCLR;
`else
    assign sclr = 1'b0;
`endif

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = (state_q != EMPTY) & bus.out_ready;

    // State register. in_ready is registered from the next state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge CLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= EMPTY;
            main_q     <= INIT;
            skid_q     <= INIT;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Next-state and datapath loads. in_data is only selected under in_fire,
    // so an undriven bus never reaches the held registers.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (sclr) begin
            state_d = EMPTY;
            main_d  = INIT;
            skid_d  = INIT;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = bus.in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        // Main is stalled: park the newer word in the skid slot.
                        skid_d  = bus.in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        bus.out_valid = (state_q != EMPTY);
        bus.occupancy = state_q;
        bus.in_ready  = in_ready_q;
        bus.out_data  = main_q;
    end

endmodule

// File: tb/tb_init_skid_buffer.sv
// tb/tb_init_skid_buffer.sv - scoreboard testbench for init_skid_buffer
module tb_init_skid_buffer;

    localparam int         WIDTH = 8;
    localparam logic [7:0] INIT  = 8'hA5;

    logic CLK    = 1'b0;
    logic PRESET = 1'b0;
    logic sclr   = 1'b0;
    logic armed;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    always #5 CLK = ~CLK;

    init_skid_buffer_if #(.WIDTH(WIDTH)) bus ();

    init_skid_buffer #(.WIDTH(WIDTH), .INIT(INIT)) dut (
        .CLK    (CLK),
        .PRESET (PRESET),
`ifdef INIT_SKID_SCLR_EN
        .SCLR   (sclr),
`endif
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // in_ready is only expected to track the model once an edge has passed since reset.
    always @(posedge CLK or posedge PRESET) begin
        if (PRESET) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // Monitor: the expected contents of the buffer are exactly the scoreboard queue.
    always @(negedge CLK) begin
        if (!PRESET) begin
            chk("occupancy", 32'(bus.occupancy), 32'(sb.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
            if (armed === 1'b1)
                chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < 2));
            chk("ready_when_full", 32'(bus.in_ready & (bus.occupancy == 2'd2)), 32'd0);
            if (bus.out_valid && bus.out_ready && !sclr) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Drive one cycle of stimulus starting just after a rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        logic       fire;
        logic [7:0] dat;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(negedge CLK);
        fire = bus.in_valid && bus.in_ready && !sclr;
        dat  = bus.in_data;
        @(posedge CLK);
        if (sclr)      sb.delete();
        else if (fire) sb.push_back(dat);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            cycle(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Preset pulse between edges.
        #2 PRESET = 1'b1;
        #1;
        chk("preset_out_data", 32'(bus.out_data), 32'(INIT));
        chk("preset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("preset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("preset_occupancy", 32'(bus.occupancy), 32'd0);
        #4 PRESET = 1'b0;
        #1;
        chk("release_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge CLK);
        #1;
        chk("release_in_ready_high", 32'(bus.in_ready), 32'd1);

        // Streaming at full rate.
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("stream_empty", 32'(bus.occupancy), 32'd0);

        // Fill, ignore while full, then drain in order.
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        chk("full_occupancy", 32'(bus.occupancy), 32'd2);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("after_first_pop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("after_first_pop_data", 32'(bus.out_data), 32'h22);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Random traffic.
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
        drain();

        // Asynchronous preset while full.
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        chk("pre_reset_full", 32'(bus.occupancy), 32'd2);
        bus.in_valid = 1'b0;
        #2 PRESET = 1'b1;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_out_data", 32'(bus.out_data), 32'(INIT));
        chk("async_occupancy", 32'(bus.occupancy), 32'd0);
        sb.delete();
        #2 PRESET = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("post_reset_data", 32'(bus.out_data), 32'(INIT));
        end
        cycle(1'b1, 8'h5A, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

`ifdef INIT_SKID_SCLR_EN
        // Synchronous clear while full with both handshakes active.
        cycle(1'b1, 8'h66, 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        chk("sclr_pre_full", 32'(bus.occupancy), 32'd2);
        sclr = 1'b1;
        cycle(1'b1, 8'h88, 1'b1);
        sclr = 1'b0;
        chk("sclr_occupancy", 32'(bus.occupancy), 32'd0);
        chk("sclr_out_data", 32'(bus.out_data), 32'(INIT));
        chk("sclr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("sclr_out_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, 8'h99, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
`endif

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
